// File: rtl/dskw_pkg.sv
// Shared types and constants for the deskew datapath sequencer.
// The shift range is fixed at 10 bits signed, which matches the 9-bit image dimension.
package dskw_pkg;

    localparam int ADDR_W_DEF  = 17;
    localparam int DIM_W_DEF   = 9;
    localparam int PIX_W_DEF   = 8;
    localparam int SLOPE_W_DEF = 12;
    localparam int FRAC_W_DEF  = 8;

    localparam int SHIFT_W   = 10;
    localparam int SHIFT_MIN = -512;
    localparam int SHIFT_MAX = 511;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROW,
        ST_COL,
        ST_WR,
        ST_DONE
    } dskw_state_e;

endpackage

// File: rtl/dskw_shift_acc.sv
// Row shear accumulator: holds r*skew_slope and presents the integer column
// shift floor(acc / 2^FRAC_W), saturated to the signed 10-bit shift range.
module dskw_shift_acc
    import dskw_pkg::*;
#(
    parameter int DIM_W   = DIM_W_DEF,
    parameter int SLOPE_W = SLOPE_W_DEF,
    parameter int FRAC_W  = FRAC_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      advance,
    input  logic [SLOPE_W-1:0]        slope,
    output logic signed [SHIFT_W-1:0] shift
);

    localparam int ACC_W = DIM_W + SLOPE_W;
    localparam logic signed [ACC_W-1:0]   SAT_HI = ACC_W'(SHIFT_MAX);
    localparam logic signed [ACC_W-1:0]   SAT_LO = ACC_W'(SHIFT_MIN);
    localparam logic signed [SHIFT_W-1:0] SH_HI  = SHIFT_W'(SHIFT_MAX);
    localparam logic signed [SHIFT_W-1:0] SH_LO  = SHIFT_W'(SHIFT_MIN);

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] acc_shr;
    logic signed [ACC_W-1:0] slope_ext;

    assign slope_ext = {{DIM_W{slope[SLOPE_W-1]}}, slope};

    always_comb begin
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (advance) begin
            acc_d = acc_q + slope_ext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Arithmetic shift floors toward minus infinity, so negative slopes round left.
    always_comb begin
        acc_shr = acc_q >>> FRAC_W;
        if (acc_shr > SAT_HI) begin
            shift = SH_HI;
        end else if (acc_shr < SAT_LO) begin
            shift = SH_LO;
        end else begin
            shift = acc_shr[SHIFT_W-1:0];
        end
    end

endmodule

// File: rtl/dskw_engine.sv
// Deskew sequencer: on dskw_start shears the source image row by row into the
// destination image through a single-port pixel RAM, then pulses dskw_done.
module dskw_engine
    import dskw_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DIM_W   = DIM_W_DEF,
    parameter int PIX_W   = PIX_W_DEF,
    parameter int SLOPE_W = SLOPE_W_DEF,
    parameter int FRAC_W  = FRAC_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               dskw_start,
    input  logic [ADDR_W-1:0]  in_img_start_addr,
    input  logic [ADDR_W-1:0]  out_img_start_addr,
    input  logic [DIM_W-1:0]   img_dim,
    input  logic [SLOPE_W-1:0] skew_slope,
    input  logic [PIX_W-1:0]   fill_pixel,
    output logic               mem_en,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [PIX_W-1:0]   mem_wdata,
    input  logic [PIX_W-1:0]   mem_rdata,
    output logic               dskw_done,
    output logic               busy
);

    localparam int SC_W = DIM_W + 2;

    dskw_state_e        state_q, state_d;
    logic [DIM_W-1:0]   r_q, r_d;
    logic [DIM_W-1:0]   c_q, c_d;
    logic [DIM_W-1:0]   dim_q, dim_d;
    logic [ADDR_W-1:0]  src_base_q, src_base_d;
    logic [ADDR_W-1:0]  dst_base_q, dst_base_d;
    logic [SLOPE_W-1:0] slope_q, slope_d;
    logic [PIX_W-1:0]   fill_q, fill_d;
    logic               sel_fill_q, sel_fill_d;

    logic                      acc_clear, acc_adv;
    logic signed [SHIFT_W-1:0] shift;
    logic signed [SC_W-1:0]    sc;
    logic                      sc_in_range;
    logic                      last_col, last_row;

    dskw_shift_acc #(
        .DIM_W   (DIM_W),
        .SLOPE_W (SLOPE_W),
        .FRAC_W  (FRAC_W)
    ) u_shift_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (acc_clear),
        .advance (acc_adv),
        .slope   (slope_q),
        .shift   (shift)
    );

    // Source column in 11-bit signed; negative or >= dim means fill.
    assign sc          = $signed({2'b00, c_q}) + $signed({{(SC_W-SHIFT_W){shift[SHIFT_W-1]}}, shift});
    assign sc_in_range = !sc[SC_W-1] && (sc[SC_W-2:0] < {1'b0, dim_q});
    assign last_col    = (c_q == dim_q - 1'b1);
    assign last_row    = (r_q == dim_q - 1'b1);
    assign busy        = (state_q != ST_IDLE);

    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        c_d        = c_q;
        dim_d      = dim_q;
        src_base_d = src_base_q;
        dst_base_d = dst_base_q;
        slope_d    = slope_q;
        fill_d     = fill_q;
        sel_fill_d = sel_fill_q;
        acc_clear  = 1'b0;
        acc_adv    = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        dskw_done  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (dskw_start) begin
                    dim_d      = img_dim;
                    src_base_d = in_img_start_addr;
                    dst_base_d = out_img_start_addr;
                    slope_d    = skew_slope;
                    fill_d     = fill_pixel;
                    r_d        = '0;
                    acc_clear  = 1'b1;
                    state_d    = (img_dim == '0) ? ST_DONE : ST_ROW;
                end
            end
            ST_ROW: begin
                c_d     = '0;
                state_d = ST_COL;
            end
            ST_COL: begin
                if (sc_in_range) begin
                    mem_en     = 1'b1;
                    mem_addr   = src_base_q + ADDR_W'(sc[SC_W-2:0]);
                    sel_fill_d = 1'b0;
                end else begin
                    sel_fill_d = 1'b1;
                end
                state_d = ST_WR;
            end
            ST_WR: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = dst_base_q + ADDR_W'(c_q);
                mem_wdata = sel_fill_q ? fill_q : mem_rdata;
                if (last_col) begin
                    if (last_row) begin
                        state_d = ST_DONE;
                    end else begin
                        r_d        = r_q + 1'b1;
                        acc_adv    = 1'b1;
                        src_base_d = src_base_q + ADDR_W'(dim_q);
                        dst_base_d = dst_base_q + ADDR_W'(dim_q);
                        state_d    = ST_ROW;
                    end
                end else begin
                    c_d     = c_q + 1'b1;
                    state_d = ST_COL;
                end
            end
            ST_DONE: begin
                dskw_done = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            r_q        <= '0;
            c_q        <= '0;
            dim_q      <= '0;
            src_base_q <= '0;
            dst_base_q <= '0;
            slope_q    <= '0;
            fill_q     <= '0;
            sel_fill_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            c_q        <= c_d;
            dim_q      <= dim_d;
            src_base_q <= src_base_d;
            dst_base_q <= dst_base_d;
            slope_q    <= slope_d;
            fill_q     <= fill_d;
            sel_fill_q <= sel_fill_d;
        end
    end

endmodule

// File: tb/tb_dskw_engine.sv
// Scoreboard bench for dskw_engine: a reference model predicts every RAM access
// in order, and a negedge monitor pops and compares each one the DUT makes.
module tb_dskw_engine;

    localparam int ADDR_W = 17;
    localparam int DIM_W  = 9;
    localparam int PIX_W  = 8;
    localparam int SLOPE_W = 12;
    localparam int FRAC_W = 8;
    localparam int RAM_SZ = 1 << ADDR_W;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               dskw_start = 1'b0;
    logic [ADDR_W-1:0]  in_img_start_addr = '0;
    logic [ADDR_W-1:0]  out_img_start_addr = '0;
    logic [DIM_W-1:0]   img_dim = '0;
    logic [SLOPE_W-1:0] skew_slope = '0;
    logic [PIX_W-1:0]   fill_pixel = '0;
    logic               mem_en, mem_we, dskw_done, busy;
    logic [ADDR_W-1:0]  mem_addr;
    logic [PIX_W-1:0]   mem_wdata;
    logic [PIX_W-1:0]   mem_rdata = '0;

    always #5 clk = ~clk;

    dskw_engine #(
        .ADDR_W (ADDR_W), .DIM_W (DIM_W), .PIX_W (PIX_W), .SLOPE_W (SLOPE_W), .FRAC_W (FRAC_W)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .dskw_start         (dskw_start),
        .in_img_start_addr  (in_img_start_addr),
        .out_img_start_addr (out_img_start_addr),
        .img_dim            (img_dim),
        .skew_slope         (skew_slope),
        .fill_pixel         (fill_pixel),
        .mem_en             (mem_en),
        .mem_we             (mem_we),
        .mem_addr           (mem_addr),
        .mem_wdata          (mem_wdata),
        .mem_rdata          (mem_rdata),
        .dskw_done          (dskw_done),
        .busy               (busy)
    );

    // Synchronous single-port RAM; contents are seeded with a pattern on the first edge.
    logic [7:0] ram [0:RAM_SZ-1];
    bit         ram_init_done = 1'b0;

    always @(posedge clk) begin
        if (!ram_init_done) begin
            for (int i = 0; i < RAM_SZ; i++) ram[i] = 8'((i * 7 + 3) ^ (i >> 8));
            ram_init_done = 1'b1;
        end
        if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
        if (mem_en && mem_we) ram[mem_addr] = mem_wdata;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Each entry: {we, addr, data}; reads carry data 0.
    logic [25:0] sb[$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        logic [25:0] e;
        if (rst_n) begin
            if (mem_we) chk("we_needs_en", 32'(mem_en), 32'd1);
            if (mem_en) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("mem_acc", {6'b0, mem_we, mem_addr, (mem_we ? mem_wdata : 8'h00)}, {6'b0, e});
                end
            end
            if (dskw_done) done_cnt++;
        end
    end

    task automatic build_expect(input int dim, input logic [16:0] inb, input logic [16:0] outb,
                                input logic [11:0] slope, input logic [7:0] fill);
        int s, acc, sh, sc, a, o;
        logic [7:0] d;
        s = int'($signed(slope));
        for (int r = 0; r < dim; r++) begin
            acc = r * s;
            sh  = acc >>> FRAC_W;
            if (sh > 511) sh = 511;
            if (sh < -512) sh = -512;
            for (int c = 0; c < dim; c++) begin
                sc = c + sh;
                if (sc >= 0 && sc < dim) begin
                    a = (int'(inb) + r * dim + sc) % RAM_SZ;
                    sb.push_back({1'b0, 17'(a), 8'h00});
                    d = ram[a];
                end else begin
                    d = fill;
                end
                o = (int'(outb) + r * dim + c) % RAM_SZ;
                sb.push_back({1'b1, 17'(o), d});
            end
        end
    endtask

    task automatic drive_start(input int dim, input logic [16:0] inb, input logic [16:0] outb,
                               input logic [11:0] slope, input logic [7:0] fill);
        @(negedge clk);
        dskw_start         = 1'b1;
        img_dim            = 9'(dim);
        in_img_start_addr  = inb;
        out_img_start_addr = outb;
        skew_slope         = slope;
        fill_pixel         = fill;
    endtask

    task automatic run_job(input string tag, input int dim, input logic [16:0] inb,
                           input logic [16:0] outb, input logic [11:0] slope,
                           input logic [7:0] fill, input bit disturb);
        int cyc;
        int d0;
        bit got;
        cyc = 0;
        got = 1'b0;
        build_expect(dim, inb, outb, slope, fill);
        d0 = done_cnt;
        drive_start(dim, inb, outb, slope, fill);
        while (!got && cyc < 5000) begin
            @(posedge clk);
            cyc++;
            #1;
            if (cyc == 1) dskw_start = 1'b0;
            if (disturb && cyc == 10) begin
                dskw_start        = 1'b1;
                img_dim           = 9'd2;
                in_img_start_addr = 17'h00000;
                skew_slope        = 12'h7FF;
                fill_pixel        = 8'h55;
            end
            if (disturb && cyc == 11) dskw_start = 1'b0;
            got = dskw_done;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(1 + dim * (1 + 2 * dim)));
        repeat (3) @(negedge clk);
        chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        chk({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
        chk({tag, "_idle_outs"}, {29'b0, busy, mem_en, dskw_done}, 32'd0);
        sb.delete();
    endtask

    initial begin
        int d0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outs", {busy, dskw_done, mem_en, mem_we, 2'b0, mem_addr, mem_wdata}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_outs", {busy, dskw_done, mem_en, mem_we, 2'b0, mem_addr, mem_wdata}, 32'd0);

        run_job("copy",     4, 17'h00100, 17'h00200, 12'h000, 8'hEE, 1'b0);
        run_job("shear1",   4, 17'h00100, 17'h00220, 12'h100, 8'hEE, 1'b0);
        run_job("shear_m05", 8, 17'h00400, 17'h00500, 12'hF80, 8'h11, 1'b0);
        run_job("bigshift", 4, 17'h00100, 17'h00240, 12'h500, 8'hA5, 1'b0);
        run_job("dim1",     1, 17'h00600, 17'h00610, 12'h7FF, 8'h3C, 1'b0);
        run_job("dim0",     0, 17'h00600, 17'h00620, 12'h100, 8'h3C, 1'b0);
        run_job("restart",  5, 17'h00700, 17'h00800, 12'h0C0, 8'h77, 1'b1);
        run_job("wrap",     4, 17'h1FFFE, 17'h00300, 12'h040, 8'h99, 1'b0);

        // Abort a job mid-row with an asynchronous reset.
        build_expect(4, 17'h00900, 17'h00A00, 12'h100, 8'h42);
        drive_start(4, 17'h00900, 17'h00A00, 12'h100, 8'h42);
        @(posedge clk);
        #1 dskw_start = 1'b0;
        repeat (6) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_outs", {29'b0, mem_en, mem_we, busy}, 32'd0);
        chk("abort_done", 32'(dskw_done), 32'd0);
        sb.delete();
        d0 = done_cnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);

        run_job("after_abort", 6, 17'h00900, 17'h00B00, 12'hF40, 8'h42, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
